// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit for the RV M-extension operations.
// Requests are captured on a valid/ready handshake; the result is presented
// on a registered valid/ready response port. kill squashes any in-flight work.
module alu_muldiv #(
  parameter int WD_SIZE  = 32,
  parameter int CNT_BITS = $clog2(WD_SIZE) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         funct3,
  input  logic [WD_SIZE-1:0] op1_data,
  input  logic [WD_SIZE-1:0] op2_data,
  input  logic               kill,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WD_SIZE-1:0] result
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WD_SIZE);
  localparam logic [WD_SIZE-1:0]  MOST_NEG = {1'b1, {(WD_SIZE-1){1'b0}}};

  state_e                 state_q, state_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [WD_SIZE-1:0]     b_q, b_d;
  logic [2*WD_SIZE-1:0]   acc_q, acc_d;
  logic                   neg_q, neg_d;
  logic                   sign1_q, sign1_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [WD_SIZE-1:0]     result_q, result_d;

  // Request decode: signedness, absolute values and special cases.
  logic                   accept;
  logic                   op1_signed, op2_signed;
  logic                   op1_neg, op2_neg;
  logic [WD_SIZE-1:0]     op1_abs, op2_abs;
  logic                   div_by_zero, div_overflow, special;
  logic [WD_SIZE-1:0]     special_res;

  assign accept       = req_valid && (state_q == ST_IDLE) && !kill;
  assign op1_signed   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
  assign op2_signed   = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                        (funct3 == 3'b110);
  assign op1_neg      = op1_signed && op1_data[WD_SIZE-1];
  assign op2_neg      = op2_signed && op2_data[WD_SIZE-1];
  assign op1_abs      = op1_neg ? -op1_data : op1_data;
  assign op2_abs      = op2_neg ? -op2_data : op2_data;
  assign div_by_zero  = (op2_data == '0);
  // Only the signed forms (DIV, REM) can overflow.
  assign div_overflow = !funct3[0] && (op1_data == MOST_NEG) && (op2_data == '1);
  assign special      = funct3[2] && (div_by_zero || div_overflow);
  // funct3[1] distinguishes the remainder forms from the quotient forms.
  assign special_res  = div_by_zero ? (funct3[1] ? op1_data : '1)
                                    : (funct3[1] ? '0 : op1_data);

  // Shift-add step: add the multiplicand into the high half when the
  // current multiplier bit (acc LSB) is set, then shift right by one.
  logic [WD_SIZE:0]       mul_sum;
  logic [2*WD_SIZE-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WD_SIZE-1:WD_SIZE]} + {1'b0, b_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WD_SIZE-1:1]}
                             : {1'b0, acc_q[2*WD_SIZE-1:WD_SIZE], acc_q[WD_SIZE-1:1]};

  // Restoring division step: acc holds {partial remainder, dividend/quotient};
  // quotient bits enter at the bottom as dividend bits leave the top.
  logic [WD_SIZE:0]       div_shift, div_diff;
  logic [2*WD_SIZE-1:0]   div_next;

  assign div_shift = {acc_q[2*WD_SIZE-1:WD_SIZE], acc_q[WD_SIZE-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_next  = div_diff[WD_SIZE]
                     ? {div_shift[WD_SIZE-1:0], acc_q[WD_SIZE-2:0], 1'b0}
                     : {div_diff[WD_SIZE-1:0],  acc_q[WD_SIZE-2:0], 1'b1};

  // Sign correction and result selection for the FIX cycle.
  logic [2*WD_SIZE-1:0]   prod_fix;
  logic [WD_SIZE-1:0]     quo_fix, rem_fix;
  logic [WD_SIZE-1:0]     fix_res;

  assign prod_fix = neg_q   ? -acc_q : acc_q;
  assign quo_fix  = neg_q   ? -acc_q[WD_SIZE-1:0] : acc_q[WD_SIZE-1:0];
  assign rem_fix  = sign1_q ? -acc_q[2*WD_SIZE-1:WD_SIZE] : acc_q[2*WD_SIZE-1:WD_SIZE];

  // Pick the half of the product, the quotient or the remainder.
  always_comb begin
    fix_res = '0;
    case (funct3_q)
      3'b000:                 fix_res = prod_fix[WD_SIZE-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WD_SIZE-1:WD_SIZE];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // Next-state logic for the controller and datapath; kill overrides all.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    funct3_d     = funct3_q;
    b_d          = b_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    sign1_d      = sign1_q;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          funct3_d = funct3;
          cnt_d    = '0;
          neg_d    = op1_neg ^ op2_neg;
          sign1_d  = op1_neg;
          b_d      = funct3[2] ? op2_abs : op1_abs;
          acc_d    = {{WD_SIZE{1'b0}}, (funct3[2] ? op1_abs : op2_abs)};
          if (special) begin
            result_d = special_res;
            state_d  = ST_DONE;
          end else begin
            state_d  = funct3[2] ? ST_DIV : ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      ST_FIX: begin
        result_d     = fix_res;
        resp_valid_d = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        // Special cases arrive here straight from IDLE; valid follows a cycle later.
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase

    if (kill && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      resp_valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      funct3_q     <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      sign1_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      funct3_q     <= funct3_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      sign1_q      <= sign1_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign result     = result_q;

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised multi-cycle integer multiply/divide unit; successor to the single-cycle add/sub ALU in the execute stage.
- Implements the eight RV M-extension operations selected by funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Uses an iterative radix-2 datapath with a valid/ready request and response handshake.
- Sits beside the base ALU; execute stalls on req_ready/resp_valid. A kill input squashes in-flight work on pipeline flush.

Parameters:
- WD_SIZE, 32: operand and result width in bits; must be ≥ 4.
- CNT_BITS, $clog2(WD_SIZE)+1: iteration counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (state IDLE).
- funct3  in  FUNCT3_BITS  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1_data  in  WD_SIZE  rs1: multiplicand or dividend.
- op2_data  in  WD_SIZE  rs2: multiplier or divisor.
- kill  in  1  abort the current operation and discard any pending response.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- result  out  WD_SIZE  operation result.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, req_ready=1, resp_valid=0, result=0, counter=0, all internal registers=0. Reset asserted mid-operation abandons the operation immediately.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. funct3, operands, and sign flags are captured at that edge; later input changes are ignored.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE→MUL on an accepted funct3[2]=0.
  - IDLE→DIV on an accepted funct3[2]=1.
  - IDLE→DONE on an accepted division special case.
  - MUL/DIV→FIX when counter reaches WD_SIZE.
  - FIX→DONE.
  - DONE→IDLE on resp_ready.
- Operand sign handling:
  - op1 is signed for MULH, MULHSU, DIV, REM.
  - op2 is signed for MULH, DIV, REM.
  - Absolute values are captured; the negate flag is computed at accept. MUL uses the low half, so signedness is irrelevant to it.
- MUL state: shift-add, one multiplier bit per cycle, 2*WD_SIZE-bit accumulator, exactly WD_SIZE cycles.
- DIV state: restoring division, one quotient bit per cycle, exactly WD_SIZE cycles.
- FIX state (1 cycle):
  - Apply two's-complement sign correction to the 2W product, or to the quotient/remainder.
  - Quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
  - Select the low half (MUL), the high half (MULH*), the quotient, or the remainder into result.
- Latency: with acceptance at edge 0, resp_valid rises after edge WD_SIZE+2 (34 for W=32). Special cases: resp_valid rises after edge 1.
- Division special cases (detected at accept):
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = op1.
  - Signed overflow, op1 = 100..0 and op2 = all ones (DIV/REM only): DIV result = op1; REM result = 0.
- DONE state: resp_valid=1 and result held stable until the edge where resp_ready=1; the next edge returns to IDLE. req_ready=0 in DONE, so no back-to-back overlap occurs; the earliest new accept is the edge after the response handshake.
- Kill:
  - kill=1 at any edge (state ≠ IDLE) forces IDLE, drops resp_valid, and produces no response.
  - Kill has priority over resp_ready and over counter completion.
  - kill=1 in IDLE blocks acceptance on that edge.
- Width rules: all arithmetic is mod 2^WD_SIZE except the internal 2W product. No X may propagate to result when inputs are legal.
- Outputs are registered (result, resp_valid); req_ready is a decode of state.

Test Plan:
- W=32, MUL 7×-3 (0x00000007, 0xFFFFFFFD), resp_ready=1 → resp_valid exactly 34 cycles after accept, result=0xFFFFFFEB; req_ready=0 throughout.
- MULH, MULHSU, MULHU with op1=0x80000000, op2=0xFFFFFFFF:
  - MULH → 0x00000000.
  - MULHSU → 0x80000000.
  - MULHU → 0x7FFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 0x00000001; each after 34 cycles.
- Special cases, each with resp_valid 1 cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000.
  - REM 0x80000000/-1 → 0.
- Backpressure: resp_ready=0 for 10 cycles after a DIVU 100/7 completes → result=14 held stable and resp_valid held; req_valid ignored; handshake, then IDLE the next cycle.
- Kill and reset:
  - kill pulsed at cycle 12 of a MUL → req_ready=1 next cycle, no resp_valid ever.
  - A new MULHU issued immediately after the kill completes correctly.
  - reset_n pulsed low mid-DIV → outputs go to reset values asynchronously.
